// File: rtl/w_ptr_full_ctrl.sv
// Write-side pointer, full/almost-full/level and overflow tracking for an async FIFO.
// The Gray write pointer leaves this block straight from a flop for the read-domain synchronizer.
`timescale 1ns/1ps

module w_ptr_full_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   w_q2_r_ptr,
    input  logic                  w_ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_overflow,
    output logic [7:0]            w_drop_cnt
);

    localparam logic [ADDR_WIDTH:0] AfullLvl = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [ADDR_WIDTH:0] w_bin;
    logic [ADDR_WIDTH:0] w_binnext;
    logic [ADDR_WIDTH:0] w_graynext;
    logic [ADDR_WIDTH:0] r_bin_sync;
    logic [ADDR_WIDTH:0] level_next;
    logic [ADDR_WIDTH:0] full_match;
    logic                full_next;
    logic                afull_next;
    logic                drop;
    logic                overflow_d;
    logic [7:0]          drop_cnt_d;

    assign w_en       = w_inc & ~w_full;
    assign w_addr     = w_bin[ADDR_WIDTH-1:0];
    assign w_binnext  = w_bin + {{ADDR_WIDTH{1'b0}}, w_en};
    assign w_graynext = (w_binnext >> 1) ^ w_binnext;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_match = {~w_q2_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], w_q2_r_ptr[ADDR_WIDTH-2:0]};
    assign full_next  = (w_graynext == full_match);

    always_comb begin
        r_bin_sync = '0;
        r_bin_sync[ADDR_WIDTH] = w_q2_r_ptr[ADDR_WIDTH];
        for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
            r_bin_sync[i] = r_bin_sync[i+1] ^ w_q2_r_ptr[i];
        end
    end

    assign level_next = w_binnext - r_bin_sync;
    assign afull_next = (level_next >= AfullLvl);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_bin         <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
        end else begin
            w_bin         <= w_binnext;
            w_ptr         <= w_graynext;
            w_full        <= full_next;
            w_almost_full <= afull_next;
            w_level       <= level_next;
        end
    end

    assign drop = w_inc & w_full;

    // A drop coinciding with a clear wins and restarts the count at one.
    always_comb begin
        overflow_d = w_overflow;
        drop_cnt_d = w_drop_cnt;
        if (drop) begin
            overflow_d = 1'b1;
            if (w_ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (w_drop_cnt != 8'hFF) begin
                drop_cnt_d = w_drop_cnt + 8'd1;
            end
        end else if (w_ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_overflow <= 1'b0;
            w_drop_cnt <= 8'd0;
        end else begin
            w_overflow <= overflow_d;
            w_drop_cnt <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
// Directed bench for w_ptr_full_ctrl at ADDR_WIDTH=4: reset, fill, overflow, drain, wrap,
// and asynchronous mid-operation reset.
`timescale 1ns/1ps

module tb_w_ptr_full_ctrl;

    localparam int unsigned AW = 4;

    logic          w_clk;
    logic          w_rst_n;
    logic          w_inc;
    logic [AW:0]   w_q2_r_ptr;
    logic          w_ovf_clr;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ptr;
    logic          w_full;
    logic          w_almost_full;
    logic [AW:0]   w_level;
    logic          w_overflow;
    logic [7:0]    w_drop_cnt;

    int n_pass  = 0;
    int n_total = 0;

    w_ptr_full_ctrl #(
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (14)
    ) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_inc         (w_inc),
        .w_q2_r_ptr    (w_q2_r_ptr),
        .w_ovf_clr     (w_ovf_clr),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_ptr         (w_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow),
        .w_drop_cnt    (w_drop_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".en"}, 32'(w_en), 32'd0);
        check({tag, ".addr"}, 32'(w_addr), 32'd0);
        check({tag, ".ptr"}, 32'(w_ptr), 32'd0);
        check({tag, ".full"}, 32'(w_full), 32'd0);
        check({tag, ".afull"}, 32'(w_almost_full), 32'd0);
        check({tag, ".level"}, 32'(w_level), 32'd0);
        check({tag, ".ovf"}, 32'(w_overflow), 32'd0);
        check({tag, ".drop"}, 32'(w_drop_cnt), 32'd0);
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW:0] b;
        logic [AW:0] prev_ptr;
        logic        saw_wrap;

        // Reset
        w_rst_n    = 1'b0;
        w_inc      = 1'b0;
        w_ovf_clr  = 1'b0;
        w_q2_r_ptr = '0;
        #1;
        check_all_zero("reset_async");
        tick();
        tick();
        w_rst_n = 1'b1;
        tick();
        check_all_zero("reset_release");

        // Fill with read pointer at 0
        for (int i = 0; i < 16; i++) begin
            w_inc = 1'b1;
            #1;
            check("fill.en", 32'(w_en), 32'd1);
            check("fill.addr", 32'(w_addr), 32'(i));
            tick();
            check("fill.level", 32'(w_level), 32'(i + 1));
            if (i == 12) check("fill.afull13", 32'(w_almost_full), 32'd0);
            if (i == 13) check("fill.afull14", 32'(w_almost_full), 32'd1);
            if (i == 14) check("fill.full15", 32'(w_full), 32'd0);
        end
        check("fill.full", 32'(w_full), 32'd1);
        check("fill.ptr", 32'(w_ptr), 32'b11000);

        // Overflow: three drops while full
        #1;
        check("ovf.en", 32'(w_en), 32'd0);
        tick();
        check("ovf.first", 32'(w_overflow), 32'd1);
        check("ovf.cnt1", 32'(w_drop_cnt), 32'd1);
        tick();
        tick();
        check("ovf.cnt3", 32'(w_drop_cnt), 32'd3);
        check("ovf.ptr_held", 32'(w_ptr), 32'b11000);
        w_inc     = 1'b0;
        w_ovf_clr = 1'b1;
        tick();
        check("clr.ovf", 32'(w_overflow), 32'd0);
        check("clr.cnt", 32'(w_drop_cnt), 32'd0);
        w_inc = 1'b1;
        tick();
        check("clr_drop.ovf", 32'(w_overflow), 32'd1);
        check("clr_drop.cnt", 32'(w_drop_cnt), 32'd1);
        w_ovf_clr = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        check("sat.cnt", 32'(w_drop_cnt), 32'd255);
        check("sat.ptr", 32'(w_ptr), 32'b11000);
        w_inc = 1'b0;

        // Drain release: read pointer binary 4
        w_q2_r_ptr = 5'b00110;
        tick();
        check("drain.full", 32'(w_full), 32'd0);
        check("drain.level", 32'(w_level), 32'd12);
        check("drain.afull", 32'(w_almost_full), 32'd0);
        check("drain.ovf_sticky", 32'(w_overflow), 32'd1);
        w_inc = 1'b1;
        #1;
        check("drain.en", 32'(w_en), 32'd1);
        check("drain.addr", 32'(w_addr), 32'd0);
        tick();
        check("drain.level13", 32'(w_level), 32'd13);
        check("drain.ptr", 32'(w_ptr), 32'b11001);
        w_inc     = 1'b0;
        w_ovf_clr = 1'b1;
        tick();
        w_ovf_clr = 1'b0;
        check("drain.clr", 32'(w_overflow), 32'd0);

        // Wrap with the read pointer trailing by 3
        b          = 5'd17;
        w_q2_r_ptr = gray(5'd14);
        tick();
        check("wrap.level0", 32'(w_level), 32'd3);
        saw_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_ptr   = w_ptr;
            w_inc      = 1'b1;
            w_q2_r_ptr = gray(b - 5'd2);
            #1;
            check("wrap.addr", 32'(w_addr), 32'(b[AW-1:0]));
            tick();
            b = b + 5'd1;
            check("wrap.level", 32'(w_level), 32'd3);
            check("wrap.full", 32'(w_full), 32'd0);
            check("wrap.ptr", 32'(w_ptr), 32'(gray(b)));
            check("wrap.onebit", 32'($countones(w_ptr ^ prev_ptr)), 32'd1);
            if (prev_ptr == 5'b10000 && w_ptr == 5'b00000) saw_wrap = 1'b1;
        end
        check("wrap.seen", 32'(saw_wrap), 32'd1);
        w_inc = 1'b0;

        // Build level 9 with overflow set, then reset between edges
        w_q2_r_ptr = gray(b - 5'd16);
        tick();
        check("mid.full", 32'(w_full), 32'd1);
        w_inc = 1'b1;
        tick();
        check("mid.ovf", 32'(w_overflow), 32'd1);
        w_inc      = 1'b0;
        w_q2_r_ptr = gray(b - 5'd9);
        tick();
        check("mid.level9", 32'(w_level), 32'd9);
        check("mid.notfull", 32'(w_full), 32'd0);
        #2;
        w_rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        w_rst_n    = 1'b1;
        w_q2_r_ptr = '0;
        w_inc      = 1'b1;
        #1;
        check("resume.en", 32'(w_en), 32'd1);
        check("resume.addr", 32'(w_addr), 32'd0);
        tick();
        check("resume.level", 32'(w_level), 32'd1);
        check("resume.ptr", 32'(w_ptr), 32'b00001);
        w_inc = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
